// File: rtl/result_drain_pkg.sv
// Shared constants for the result drain: word width, header layout and FSM encoding.
// Also provides the header word builder used by the top.
package result_drain_pkg;

  localparam int          RD_DATA_WIDTH = 32;
  localparam logic [7:0]  RD_HDR_MAGIC  = 8'hC5;

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_HDR  = 2'd1;
  localparam logic [1:0]  ST_BODY = 2'd2;
  localparam logic [1:0]  ST_CSUM = 2'd3;

  localparam int          HDR_MAGIC_LSB = 24;
  localparam int          HDR_SEQ_LSB   = 16;
  localparam int          HDR_LEN_LSB   = 0;

  function automatic logic [31:0] make_header(input logic [7:0]  magic,
                                              input logic [7:0]  seq,
                                              input logic [15:0] len);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 8]  = magic;
    h[HDR_SEQ_LSB   +: 8]  = seq;
    h[HDR_LEN_LSB   +: 16] = len;
    return h;
  endfunction

endpackage

// File: rtl/result_drain_if.sv
// Source FIFO read port plus downstream write port of the result drain.
// master = drain side, slave = FIFO/downstream side.
interface result_drain_if
  import result_drain_pkg::*;
#(
  parameter int DATA_WIDTH = RD_DATA_WIDTH
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_wren;
  logic                  out_full;

  modport master (
    input  fifo_empty, fifo_dout, out_full,
    output fifo_rd_en, out_data, out_wren
  );

  modport slave (
    output fifo_empty, fifo_dout, out_full,
    input  fifo_rd_en, out_data, out_wren
  );
endinterface

// File: rtl/result_drain_skid_buf2.sv
// Two-entry FIFO-ordered push/pop buffer with occupancy output; push and pop may coincide.
module result_drain_skid_buf2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       occupancy
);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic [1:0]            occ_q, occ_d, occ_pop;

  // Pop shifts entry 1 to the head; a push then lands in the first free slot.
  always_comb begin
    occ_pop = occ_q - {1'b0, pop};
    mem_d   = mem_q;
    if (pop)  mem_d[0] = mem_q[1];
    if (push) mem_d[occ_pop[0]] = push_data;
    occ_d   = occ_pop + {1'b0, push};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      occ_q <= occ_d;
    end
  end

  assign head_data  = mem_q[0];
  assign head_valid = (occ_q != 2'd0);
  assign occupancy  = occ_q;

endmodule

// File: rtl/result_drain.sv
// Drains the result FIFO into a downstream write port, framing FRAME_WORDS words behind a header.
// Define RESULT_DRAIN_CSUM_EN to append an XOR-of-body trailer word to every frame.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int         DATA_WIDTH  = RD_DATA_WIDTH,
  parameter int         FRAME_WORDS = 8,
  parameter logic [7:0] HDR_MAGIC   = RD_HDR_MAGIC
) (
  input  logic           bus_clk,
  input  logic           user_r_read_32_open,
  result_drain_if.master bus,
  output logic [15:0]    frame_count,
  output logic           busy
);

  localparam logic [15:0] FW16 = 16'(FRAME_WORDS);

  logic [1:0]            state_q, state_d;
  logic [15:0]           issued_q, issued_d;
  logic                  inflight_q;
  logic [7:0]            seq_q, seq_d;
  logic [15:0]           fcnt_q, fcnt_d;
`ifdef RESULT_DRAIN_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  logic                  pop, push, room, rd_en, last_land, head_valid;
  logic [DATA_WIDTH-1:0] push_data, head_data;
  logic [1:0]            occ, occ_pop;

  assign pop          = head_valid & ~bus.out_full;
  assign bus.out_wren = pop;
  assign bus.out_data = head_data;

  // Space is judged after this cycle's pop and counting the read still in flight.
  assign occ_pop   = occ - {1'b0, pop};
  assign room      = (occ_pop + {1'b0, inflight_q}) < 2'd2;
  assign rd_en     = (state_q == ST_BODY) & ~bus.fifo_empty & (issued_q < FW16) & room;
  assign last_land = (state_q == ST_BODY) & inflight_q & (issued_q == FW16);
  assign bus.fifo_rd_en = rd_en;

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    seq_d     = seq_q;
    fcnt_d    = fcnt_q;
    push      = inflight_q;
    push_data = bus.fifo_dout;
`ifdef RESULT_DRAIN_CSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_IDLE: if (!bus.fifo_empty) state_d = ST_HDR;
      ST_HDR: begin
        if (room) begin
          push      = 1'b1;
          push_data = make_header(HDR_MAGIC, seq_q, FW16);
          issued_d  = '0;
`ifdef RESULT_DRAIN_CSUM_EN
          csum_d    = '0;
`endif
          state_d   = ST_BODY;
        end
      end
      ST_BODY: begin
        if (rd_en) issued_d = issued_q + 16'd1;
`ifdef RESULT_DRAIN_CSUM_EN
        if (inflight_q) csum_d = csum_q ^ bus.fifo_dout;
        if (last_land) state_d = ST_CSUM;
`else
        if (last_land) begin
          state_d = ST_IDLE;
          seq_d   = seq_q + 8'd1;
          fcnt_d  = fcnt_q + 16'd1;
        end
`endif
      end
`ifdef RESULT_DRAIN_CSUM_EN
      ST_CSUM: begin
        if (room) begin
          push      = 1'b1;
          push_data = csum_q;
          state_d   = ST_IDLE;
          seq_d     = seq_q + 8'd1;
          fcnt_d    = fcnt_q + 16'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or negedge user_r_read_32_open) begin
    if (!user_r_read_32_open) begin
      state_q    <= ST_IDLE;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      seq_q      <= '0;
      fcnt_q     <= '0;
`ifdef RESULT_DRAIN_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      inflight_q <= rd_en;
      seq_q      <= seq_d;
      fcnt_q     <= fcnt_d;
`ifdef RESULT_DRAIN_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  result_drain_skid_buf2 #(
    .WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk        (bus_clk),
    .rst_n      (user_r_read_32_open),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .occupancy  (occ)
  );

  assign frame_count = fcnt_q;
  assign busy        = (state_q != ST_IDLE) | (occ != 2'd0);

endmodule

// File: tb/tb_result_drain.sv
// Randomized bench for result_drain (FRAME_WORDS=4) against a queue-based frame model.
// Honours RESULT_DRAIN_CSUM_EN when the build defines it.
module tb_result_drain;

  localparam int FW = 4;

  typedef struct packed {
    logic [31:0] d;
    logic        body;
  } exp_t;

  logic        bus_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] frame_count;
  logic        busy;

  result_drain_if #(.DATA_WIDTH(32)) bus ();

  result_drain #(
    .DATA_WIDTH  (32),
    .FRAME_WORDS (FW),
    .HDR_MAGIC   (8'hC5)
  ) dut (
    .bus_clk             (bus_clk),
    .user_r_read_32_open (rst_n),
    .bus                 (bus),
    .frame_count         (frame_count),
    .busy                (busy)
  );

  always #5 bus_clk = ~bus_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          full_mode = 0;
  logic [31:0] srcq[$];
  exp_t        expq[$];
  int          mseq = 0, mpos = 0, mframes = 0;
  logic [31:0] macc = '0;
  int          reads = 0, body_out = 0, ph_out = 0;
  logic        want_lat = 1'b0;
  int          t_start = 0;
  logic        pend_go = 1'b0;
  logic [31:0] pend_word = '0;

  // Source FIFO read port: dout follows rd_en by one cycle.
  always @(posedge bus_clk) if (pend_go) bus.fifo_dout <= pend_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] hdr(input int s);
    logic [7:0]  s8;
    logic [15:0] len;
    s8  = 8'(s % 256);
    len = 16'(FW);
    return {8'hC5, s8, len};
  endfunction

  task automatic src_push(input logic [31:0] w);
    srcq.push_back(w);
    if (mpos == 0) begin
      expq.push_back(exp_t'{d: hdr(mseq), body: 1'b0});
      macc = '0;
    end
    expq.push_back(exp_t'{d: w, body: 1'b1});
    macc = macc ^ w;
    mpos++;
    if (mpos == FW) begin
`ifdef RESULT_DRAIN_CSUM_EN
      expq.push_back(exp_t'{d: macc, body: 1'b0});
`endif
      mpos = 0;
      mseq++;
      mframes++;
    end
  endtask

  task automatic model_reset();
    srcq.delete();
    expq.delete();
    mseq = 0; mpos = 0; mframes = 0; macc = '0;
    reads = 0; body_out = 0;
    pend_go = 1'b0;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge bus_clk);
    cyc++;
    case (full_mode)
      1:       bus.out_full = (cyc % 3 == 0);
      2:       bus.out_full = ($urandom_range(3) == 0);
      3:       bus.out_full = 1'b1;
      default: bus.out_full = 1'b0;
    endcase
    bus.fifo_empty = (srcq.size() == 0);
    #1;
    if (bus.out_full) chk("wren_full", {31'd0, bus.out_wren}, 32'd0);
    if (bus.out_wren) begin
      if (want_lat) begin
        chk("hdr_latency", cyc, t_start + 2);
        want_lat = 1'b0;
      end
      if (expq.size() == 0) chk("extra_word", {31'd0, bus.out_wren}, 32'd0);
      else begin
        e = expq.pop_front();
        chk("data", bus.out_data, e.d);
        if (e.body) body_out++;
        ph_out++;
      end
    end
    pend_go = 1'b0;
    if (bus.fifo_rd_en) begin
      chk("rd_empty", {31'd0, bus.fifo_empty}, 32'd0);
      chk("rd_cap", {31'd0, (reads - body_out) <= 1}, 32'd1);
      if (srcq.size() != 0) begin
        pend_word = srcq.pop_front();
        pend_go   = 1'b1;
        reads++;
      end
    end
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    do begin
      tick();
      i++;
    end while (!(expq.size() == 0 && srcq.size() == 0 && !busy && !bus.out_wren) && i < budget);
    chk("drain_busy", {31'd0, busy}, 32'd0);
    chk("drain_left", expq.size(), 32'd0);
  endtask

  initial begin
    int i, b0, n;
    bus.out_full   = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;
    repeat (3) @(negedge bus_clk);
    #1;
    chk("rst_wren", {31'd0, bus.out_wren}, 32'd0);
    chk("rst_rd", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("rst_fc", {16'd0, frame_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    @(negedge bus_clk);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic frame and header latency.
    full_mode = 0;
    for (int k = 1; k <= 4; k++) src_push(32'(k));
    t_start  = cyc + 1;
    want_lat = 1'b1;
    drain(100);
    chk("lat_seen", {31'd0, want_lat}, 32'd0);
    chk("fc_basic", {16'd0, frame_count}, 32'd1);

    // Backpressure: hold full, then toggle 1 high / 2 low.
    for (int k = 1; k <= 8; k++) src_push(32'(k));
    full_mode = 3;
    repeat (8) tick();
    chk("full_hold_rd", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("full_hold_busy", {31'd0, busy}, 32'd1);
    full_mode = 1;
    drain(200);
    chk("fc_bp", {16'd0, frame_count}, 32'd3);

    // Source runs dry mid-frame.
    full_mode = 0;
    ph_out = 0;
    src_push(32'hA5A5_0001);
    src_push(32'hA5A5_0002);
    repeat (12) tick();
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_out", ph_out, 32'd3);
    chk("stall_fc", {16'd0, frame_count}, 32'd3);
    src_push(32'hA5A5_0003);
    src_push(32'hA5A5_0004);
    drain(100);
    chk("fc_stall", {16'd0, frame_count}, 32'd4);

    // Sequence number wrap over 256 frames.
    full_mode = 2;
    for (int k = 0; k < 252 * FW; k++) src_push($urandom);
    drain(20000);
    chk("fc_256", {16'd0, frame_count}, 32'd256);
    for (int k = 0; k < FW; k++) src_push($urandom);
    drain(200);
    chk("fc_257", {16'd0, frame_count}, 32'd257);

    // Random arrivals with random backpressure.
    n = 0;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(1) == 1) begin
        src_push($urandom);
        n++;
      end
      tick();
    end
    while (n % FW != 0) begin
      src_push($urandom);
      n++;
    end
    drain(2000);
    chk("fc_rand", {16'd0, frame_count}, 32'(mframes));

    // Asynchronous reset in the middle of a frame.
    full_mode = 0;
    for (int k = 0; k < FW; k++) src_push(32'h0BAD_0000 + 32'(k));
    b0 = body_out;
    i = 0;
    while (body_out - b0 < 2 && i < 50) begin
      tick();
      i++;
    end
    chk("rst_wait", body_out - b0, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_wren", {31'd0, bus.out_wren}, 32'd0);
    chk("arst_rd", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("arst_fc", {16'd0, frame_count}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    bus.fifo_empty = 1'b1;
    @(posedge bus_clk);
    @(negedge bus_clk);
    rst_n = 1'b1;
    for (int k = 1; k <= FW; k++) src_push(32'h1000 + 32'(k));
    chk("post_rst_hdr", expq[0].d, 32'hC500_0004);
    drain(100);
    chk("fc_post_rst", {16'd0, frame_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Reader-side counterpart of the overlay's result FIFO.
- Pops 32-bit result words from a standard (non-FWFT) FIFO read port: empty/rd_en/dout, with dout valid one cycle after rd_en.
- Frames each FRAME_WORDS results behind a generated header word.
- Pushes the frame into a downstream write-style port (wren/data/full), e.g. a host write channel or the next overlay's input pipe. A 2-entry skid buffer absorbs full backpressure.

Parameters:
- DATA_WIDTH, 32, word width (fixed 32: header layout depends on it).
- FRAME_WORDS, 8, result words per frame; legal 1..65535.
- HDR_MAGIC, 8'hC5, header bits [31:24].

Ports:
- bus_clk  in  1  clock.
- user_r_read_32_open  in  1  asynchronous active-low reset; low clears all state.
- fifo_empty  in  1  source FIFO empty.
- fifo_rd_en  out  1  source FIFO pop.
- fifo_dout  in  DATA_WIDTH  source data, valid the cycle after fifo_rd_en.
- out_data  out  DATA_WIDTH  downstream data.
- out_wren  out  1  downstream write strobe.
- out_full  in  1  downstream full (backpressure).
- frame_count  out  16  completed frames, wraps at 65535->0.
- busy  out  1  high whenever state != IDLE or the buffer is non-empty.

Behaviour:
- Reset: user_r_read_32_open low asynchronously clears FSM to IDLE, buffer, in-flight flag, word counter and seq. All outputs go to 0. An interrupted frame is discarded, never completed.
- Skid buffer: 2 entries, FIFO order.
  - out_data = head entry; out_wren = head_valid & !out_full.
  - A pop occurs on out_wren. A push and a pop in the same cycle are both legal.
- Read issue: fifo_rd_en = (state==BODY) & !fifo_empty & (issued < FRAME_WORDS) & (occupancy + inflight < 2), where occupancy is after this cycle's pop.
  - The word read lands in the buffer one cycle later (inflight=1 during that cycle).
- FSM states:
  - IDLE: if !fifo_empty -> HDR.
  - HDR: when occupancy + inflight < 2, push header {HDR_MAGIC, seq[7:0], FRAME_WORDS[15:0]}, clear issued, -> BODY.
  - BODY: issue reads as above; issued increments per rd_en. After the FRAME_WORDS-th word lands in the buffer:
    - without the optional feature: -> IDLE, frame_count+1, seq+1 (8-bit wrap);
    - with it: -> CSUM.
  - CSUM (optional feature only): covered under Optional Feature.
- Latency, with out_full low: first fifo_empty deassert at cycle T gives HDR at T+1 and header out_wren at T+2. Body words then stream at 1 word/cycle.
- out_full held high: buffer fills to 2 and fifo_rd_en stays low. No word is dropped or duplicated. Output resumes the cycle out_full falls.
- fifo_empty rising mid-frame: the frame stalls in BODY indefinitely; there is no timeout.
- frame_count and seq increment on the same edge the frame's last word is pushed into the buffer, not when it is written out.

Optional Feature:
- Macro RESULT_DRAIN_CSUM_EN.
- Defined:
  - A running XOR of all body words is kept per frame.
  - CSUM state pushes that XOR as a trailer word when occupancy + inflight < 2, then -> IDLE; frame_count+1 and seq+1 on that push.
  - Frame length on the wire is FRAME_WORDS+2.
- Undefined: no accumulator, no CSUM state; frame is FRAME_WORDS+1 words.

Decomposition:
- Shared package/defines header: DATA_WIDTH, HDR_MAGIC, FSM state encoding (IDLE=0, HDR=1, BODY=2, CSUM=3), header field bit positions.
- One natural sub-module: skid_buf2, a 2-entry push/pop buffer with occupancy output. It is reusable for other overlay egress ports.

Test Plan:
- FRAME_WORDS=4, FIFO holds 1,2,3,4, out_full=0 -> out_data sequence C5000004,1,2,3,4 on consecutive out_wren cycles; header at T+2; frame_count=1; busy low afterwards.
- Same with RESULT_DRAIN_CSUM_EN -> C5000004,1,2,3,4,00000004; frame_count=1.
- 8 words queued, out_full toggling 1 high/2 low -> two frames with headers C5000004 then C5010004, body 1..8 in order, no loss or duplication. fifo_rd_en never asserts while occupancy+inflight=2.
- FIFO supplies 2 words, then goes empty for 10 cycles, then 2 more -> stall in BODY with busy=1; frame completes with words intact.
- user_r_read_32_open pulsed low after the second body word -> out_wren, fifo_rd_en and frame_count drop to 0 immediately, with no clock edge needed. The next frame header carries seq 00.
- 256 frames with FRAME_WORDS=1 -> header seq wraps FF->00; frame_count=256.
